// File: rtl/struct_bus_pkg.sv
// Shared types for the packed three-field data bus.
// Used by the serializer and the matching deserializer.
package struct_bus_pkg;

  localparam int NUM_FIELDS = 3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } data_bus_8bit_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } data_bus_16bit_t;

  typedef enum logic [1:0] {
    FIELD_A = 2'd0,
    FIELD_B = 2'd1,
    FIELD_C = 2'd2
  } field_tag_e;

  // Serializer states: MSB = busy, low bits = field tag being sent.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SEND_A = {1'b1, FIELD_A},
    SEND_B = {1'b1, FIELD_B},
    SEND_C = {1'b1, FIELD_C}
  } ser_state_e;

endpackage

// File: rtl/struct_bus_serializer.sv
// Struct bus serializer: one struct in, fields a, b, c out.
// Back-to-back frames are accepted on the c beat.
module struct_bus_serializer
  import struct_bus_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_FIELDS*WIDTH-1:0] in_bus,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [1:0]                  out_field,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            frame_cnt
);

  ser_state_e                  state;
  ser_state_e                  state_nxt;
  field_tag_e                  tag;
  logic [NUM_FIELDS*WIDTH-1:0] hold;
  logic [CNT_W-1:0]            cnt;
  logic                        in_xfer;
  logic                        out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_field = tag;
  assign frame_cnt = cnt;

  // Next state, handshake and beat outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    tag       = FIELD_A;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND_A;
      end
      SEND_A: begin
        out_valid = 1'b1;
        out_data  = hold[3*WIDTH-1:2*WIDTH];
        tag       = FIELD_A;
        if (out_ready) state_nxt = SEND_B;
      end
      SEND_B: begin
        out_valid = 1'b1;
        out_data  = hold[2*WIDTH-1:WIDTH];
        tag       = FIELD_B;
        if (out_ready) state_nxt = SEND_C;
      end
      SEND_C: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = hold[WIDTH-1:0];
        tag       = FIELD_C;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? SEND_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Holding register, written only on an input transfer.
  always_ff @(posedge clk) begin
    if (rst)          hold <= '0;
    else if (in_xfer) hold <= in_bus;
  end

  // Completed-frame counter, wraps freely.
  always_ff @(posedge clk) begin
    if (rst)                              cnt <= '0;
    else if (out_xfer && state == SEND_C) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_struct_bus_serializer.sv
// Directed bench for struct_bus_serializer.
// 16-bit instance plus an 8-bit instance with a 4-bit counter.
module tb_struct_bus_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic [47:0] in_bus16;
  logic        in_valid16, in_ready16;
  logic [15:0] out_data16;
  logic [1:0]  out_field16;
  logic        out_last16, out_valid16, out_ready16;
  logic [15:0] frame_cnt16;

  logic [23:0] in_bus8;
  logic        in_valid8, in_ready8;
  logic [7:0]  out_data8;
  logic [1:0]  out_field8;
  logic        out_last8, out_valid8, out_ready8;
  logic [3:0]  frame_cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  struct_bus_serializer #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_bus(in_bus16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_data(out_data16), .out_field(out_field16),
    .out_last(out_last16), .out_valid(out_valid16),
    .out_ready(out_ready16), .frame_cnt(frame_cnt16)
  );

  struct_bus_serializer #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_bus(in_bus8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_field(out_field8),
    .out_last(out_last8), .out_valid(out_valid8),
    .out_ready(out_ready8), .frame_cnt(frame_cnt8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat16(input string tag, input logic [15:0] d,
                        input logic [1:0] f, input logic l);
    chk({tag, ".valid"}, 64'(out_valid16), 64'(1'b1));
    chk({tag, ".data"}, 64'(out_data16), 64'(d));
    chk({tag, ".field"}, 64'(out_field16), 64'(f));
    chk({tag, ".last"}, 64'(out_last16), 64'(l));
  endtask

  task automatic beat8(input string tag, input logic [7:0] d,
                       input logic [1:0] f, input logic l);
    chk({tag, ".valid"}, 64'(out_valid8), 64'(1'b1));
    chk({tag, ".data"}, 64'(out_data8), 64'(d));
    chk({tag, ".field"}, 64'(out_field8), 64'(f));
    chk({tag, ".last"}, 64'(out_last8), 64'(l));
  endtask

  // One isolated 8-bit frame; returns at a negedge in IDLE.
  task automatic frame8(input logic [23:0] bus);
    @(negedge clk);
    in_valid8 = 1'b1;
    in_bus8   = bus;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    in_bus16    = '0;
    in_valid16  = 1'b0;
    out_ready16 = 1'b0;
    in_bus8     = '0;
    in_valid8   = 1'b0;
    out_ready8  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready16), 64'd0);
    chk("rst.out_valid", 64'(out_valid16), 64'd0);
    chk("rst.frame_cnt", 64'(frame_cnt16), 64'd0);
    chk("rst.out_data", 64'(out_data16), 64'd0);
    chk("rst.out_field", 64'(out_field16), 64'd0);
    chk("rst.out_last", 64'(out_last16), 64'd0);
    chk("rst.in_ready8", 64'(in_ready8), 64'd0);

    // Idle, X on in_bus while not valid
    @(negedge clk);
    rst      = 1'b0;
    in_bus16 = 'x;
    #1;
    chk("idle.in_ready", 64'(in_ready16), 64'd1);
    chk("idle.x_data", 64'(out_data16), 64'd0);

    // Single frame
    @(negedge clk);
    in_valid16  = 1'b1;
    in_bus16    = {16'h1111, 16'h2222, 16'h3333};
    out_ready16 = 1'b1;
    #1;
    chk("t1.pre_valid", 64'(out_valid16), 64'd0);
    @(negedge clk);
    in_valid16 = 1'b0;
    in_bus16   = 'x;
    #1;
    beat16("t1.a", 16'h1111, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    beat16("t1.b", 16'h2222, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    beat16("t1.c", 16'h3333, 2'd2, 1'b1);
    chk("t1.c_in_ready", 64'(in_ready16), 64'd1);
    @(negedge clk);
    #1;
    chk("t1.idle", 64'(out_valid16), 64'd0);
    chk("t1.cnt", 64'(frame_cnt16), 64'd1);

    // Back-to-back frames
    @(negedge clk);
    in_valid16 = 1'b1;
    in_bus16   = {16'hA1A1, 16'hB1B1, 16'hC1C1};
    @(negedge clk);
    in_bus16 = {16'hA2A2, 16'hB2B2, 16'hC2C2};
    #1;
    beat16("t2.a1", 16'hA1A1, 2'd0, 1'b0);
    chk("t2.a1_in_ready", 64'(in_ready16), 64'd0);
    @(negedge clk);
    #1;
    beat16("t2.b1", 16'hB1B1, 2'd1, 1'b0);
    chk("t2.b1_in_ready", 64'(in_ready16), 64'd0);
    @(negedge clk);
    #1;
    beat16("t2.c1", 16'hC1C1, 2'd2, 1'b1);
    chk("t2.c1_in_ready", 64'(in_ready16), 64'd1);
    @(negedge clk);
    in_valid16 = 1'b0;
    in_bus16   = 'x;
    #1;
    beat16("t2.a2", 16'hA2A2, 2'd0, 1'b0);
    chk("t2.cnt_mid", 64'(frame_cnt16), 64'd2);
    @(negedge clk);
    #1;
    beat16("t2.b2", 16'hB2B2, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    beat16("t2.c2", 16'hC2C2, 2'd2, 1'b1);
    @(negedge clk);
    #1;
    chk("t2.idle", 64'(out_valid16), 64'd0);
    chk("t2.cnt", 64'(frame_cnt16), 64'd3);

    // Reset during SEND_B
    @(negedge clk);
    in_valid16 = 1'b1;
    in_bus16   = {16'hDEAD, 16'hBEEF, 16'hF00D};
    @(negedge clk);
    in_valid16 = 1'b0;
    in_bus16   = 'x;
    @(negedge clk);
    #1;
    beat16("t3.b", 16'hBEEF, 2'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t3.rst_in_ready", 64'(in_ready16), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t3.valid", 64'(out_valid16), 64'd0);
    chk("t3.cnt", 64'(frame_cnt16), 64'd0);
    chk("t3.in_ready", 64'(in_ready16), 64'd1);
    in_valid16 = 1'b1;
    in_bus16   = {16'h1234, 16'h5678, 16'h9ABC};
    @(negedge clk);
    in_valid16 = 1'b0;
    in_bus16   = 'x;
    #1;
    beat16("t3.a", 16'h1234, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    beat16("t3.b2", 16'h5678, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    beat16("t3.c", 16'h9ABC, 2'd2, 1'b1);
    @(negedge clk);
    #1;
    chk("t3.cnt_end", 64'(frame_cnt16), 64'd1);

    // 8-bit: stall during the b beat
    @(negedge clk);
    in_valid8  = 1'b1;
    in_bus8    = {8'hAA, 8'hBB, 8'hCC};
    out_ready8 = 1'b1;
    @(negedge clk);
    in_bus8 = {8'h11, 8'h22, 8'h33};
    #1;
    beat8("t4.a", 8'hAA, 2'd0, 1'b0);
    chk("t4.a_in_ready", 64'(in_ready8), 64'd0);
    @(negedge clk);
    out_ready8 = 1'b0;
    #1;
    beat8("t4.b", 8'hBB, 2'd1, 1'b0);
    chk("t4.b_in_ready", 64'(in_ready8), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      beat8("t4.stall", 8'hBB, 2'd1, 1'b0);
      chk("t4.stall_in_ready", 64'(in_ready8), 64'd0);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    #1;
    beat8("t4.c", 8'hCC, 2'd2, 1'b1);
    chk("t4.c_in_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    in_bus8   = 'x;
    #1;
    beat8("t4.a2", 8'h11, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    beat8("t4.b2", 8'h22, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    beat8("t4.c2", 8'h33, 2'd2, 1'b1);
    @(negedge clk);
    #1;
    chk("t4.cnt", 64'(frame_cnt8), 64'd2);

    // 4-bit counter wrap
    for (int i = 0; i < 13; i++) frame8(24'h010203);
    #1;
    chk("t5.cnt15", 64'(frame_cnt8), 64'd15);
    frame8({8'h5A, 8'h6B, 8'h7C});
    #1;
    chk("t5.wrap0", 64'(frame_cnt8), 64'd0);
    chk("t5.idle", 64'(out_valid8), 64'd0);
    @(negedge clk);
    in_valid8 = 1'b1;
    in_bus8   = {8'h5A, 8'h6B, 8'h7C};
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    beat8("t5.a", 8'h5A, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("t5.wrap1", 64'(frame_cnt8), 64'd1);
    chk("t5.in_ready", 64'(in_ready8), 64'd1);
    chk("t5.cnt16_quiet", 64'(frame_cnt16), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
